mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor of the pipeline memory-stage controller.
- Executes decoded LDR/STR operations against an external data memory through a valid/ready request channel and a valid response channel. Memory latency is variable.
- Stalls upstream while an access is in flight and drops accesses from a stale branch epoch.
- Produces one register-writeback beat per load, with byte/half/word/dword sizing and sign/zero extension.

Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- EPOCH_W, 1, branch-epoch width; generalises the single branch-reference bit.
- TIMEOUT, 255, cycles to wait for a load response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  unit can accept an operation
- in_op  in  2  00 none, 01 LDR, 10 STR, 11 reserved (treated as none)
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword
- in_signed  in  1  sign-extend load data
- in_addr  in  ADDR_W  effective byte address (already pre/post-indexed)
- in_wdata  in  DATA_W  store data, LSB-aligned
- in_rd  in  4  load destination register
- in_epoch  in  EPOCH_W  epoch tag of the operation
- cur_epoch  in  EPOCH_W  global branch epoch
- flush  in  1  suppress the writeback of the in-flight op
- stall  out  1  in_valid && !in_ready
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  1 = store
- mem_req_addr  out  ADDR_W  address aligned down to DATA_W/8
- mem_req_wdata  out  DATA_W  store data replicated across lanes
- mem_req_be  out  DATA_W/8  byte enables
- mem_rsp_valid  in  1  load data valid
- mem_rsp_rdata  in  DATA_W  load data
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  4  writeback register
- wb_data  out  DATA_W  extended load data
- err_misalign  out  1  one-cycle pulse
- err_timeout  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE. All outputs and internal registers are 0, except in_ready=1 (combinational from IDLE).
- FSM states: IDLE, REQ, RSP, DRAIN.
- Accept fires on in_valid && in_ready. On accept the unit registers op, size, signed, addr, wdata and rd.
- IDLE, accept, in_op none/reserved: stay in IDLE. No outputs.
- IDLE, accept, in_epoch != cur_epoch: squash. Stay in IDLE, no request, no error.
- IDLE, accept, misaligned: stay in IDLE and pulse err_misalign the next cycle. Misaligned means any of:
  - half with addr[0] != 0
  - word with addr[1:0] != 0
  - dword with addr[2:0] != 0
  - dword when DATA_W=32
- IDLE, accept, otherwise: go to REQ.
- REQ: mem_req_valid=1. Request fields stay stable until mem_req_ready.
  - On the handshake, a store returns to IDLE (posted write, no writeback).
  - On the handshake, a load goes to RSP and clears the timeout counter.
- Lane and be:
  - lane = addr[log2(DATA_W/8)-1:0].
  - be = (size mask: 1, 3, 0xF or 0xFF) shifted left by lane.
- RSP:
  - On mem_rsp_valid: the next cycle, wb_valid=1 and wb_rd=rd, unless the flush flag is set. Then return to IDLE.
  - wb_data = rdata shifted right by lane*8, truncated to the size, then sign- or zero-extended to DATA_W.
  - Timeout: the counter increments each cycle. When TIMEOUT != 0 and count == TIMEOUT-1 with no response, pulse err_timeout, go to DRAIN, and produce no writeback.
- DRAIN: waits for and discards exactly one mem_rsp_valid, then returns to IDLE. A response arriving in the same cycle as the timeout still goes to DRAIN; the next response is discarded.
- Flush flag:
  - Set when flush is high, or when cur_epoch != the captured epoch, in REQ or RSP.
  - Cleared on the return to IDLE.
  - A flush during REQ still completes the handshake; a store still writes.
- in_ready=1 only in IDLE. Back-to-back accepts are possible only for squashed, none or misaligned ops. A new op can be accepted in the same cycle wb_valid pulses (the FSM is already in IDLE).
- mem_rsp_valid in IDLE or REQ is ignored.
- Reset mid-operation: immediate return to IDLE. The outstanding response is not tracked (the memory is reset by the same rst).

Decomposition:
- Package mem_access_pkg: op encodings, size encodings, state enum, and a size-mask function.
- One sub-module, mem_lane_align: combinational byte-enable/replication for stores and shift/extend for loads. The FSM, counter and flags stay in the top level.

Test Plan:
- Word store, DATA_W=32, addr 0x104, wdata 0xDEADBEEF, mem_req_ready held low 3 cycles -> req fields stable 4 cycles, be=4'hF, addr 0x104, stall high meanwhile, no wb.
- Signed byte load, addr 0x103, rsp rdata 0x80_00_00_00 after 5 cycles -> be=4'h8, wb_valid 1 cycle after rsp, wb_data 0xFFFFFF80, wb_rd=in_rd.
- Half load at 0x101 -> err_misalign pulse, no mem_req_valid. Dword request with DATA_W=32 -> same result.
- in_epoch=0 while cur_epoch=1 -> accepted, in_ready stays 1, no request. cur_epoch toggling during RSP -> response consumed, wb_valid stays 0.
- TIMEOUT=4, no response -> err_timeout 4 cycles after the handshake. A late response 10 cycles later is discarded, then IDLE. The next load completes normally.
- DATA_W=64, unsigned half load at addr 0x6, rdata 0x1234_0000_0000_0000 -> be=8'hC0, wb_data 0x1234. rst asserted in RSP -> outputs 0 immediately, in_ready=1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the memory access unit.
//   op_e    - decoded memory operation (none / load / store / reserved)
//   size_e  - access size (byte / half / word / dword)
//   state_e - access FSM state, also exported on the debug port
//   size_mask() - byte-lane mask for an access size, LSB-aligned
package mem_access_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_LDR  = 2'b01,
    OP_STR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_RSP   = 2'b10,
    ST_DRAIN = 2'b11
  } state_e;

  function automatic logic [7:0] size_mask(input size_e size);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: purely combinational data steering between register
// and memory bus views.
//   size_i, signed_i, lane_i - access descriptor (lane = byte offset in bus)
//   wdata_i    -> wdata_rep_o : store data replicated across every lane
//   be_o                      : byte enables, size mask shifted to the lane
//   rdata_i    -> rdata_ext_o : load data shifted down, truncated, extended
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [NB-1:0]     be_o,
  output logic [DATA_W-1:0] wdata_rep_o,
  output logic [DATA_W-1:0] rdata_ext_o
);

  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign_bit;

  assign mask = NB'(size_mask(size_i));
  assign be_o = mask << lane_i;

  // Each bus byte takes the store byte at the same position modulo the
  // access size, so the memory sees valid data whichever lane is enabled.
  always_comb begin
    wdata_rep_o = '0;
    for (int i = 0; i < NB; i++) begin
      case (size_i)
        SZ_BYTE: wdata_rep_o[i*8 +: 8] = wdata_i[7:0];
        SZ_HALF: wdata_rep_o[i*8 +: 8] = wdata_i[(i%2)*8 +: 8];
        SZ_WORD: wdata_rep_o[i*8 +: 8] = wdata_i[(i%4)*8 +: 8];
        default: wdata_rep_o[i*8 +: 8] = wdata_i[(i%NB)*8 +: 8];
      endcase
    end
  end

  // Extension is done with a keep-mask rather than concatenations so the
  // word case still elaborates cleanly when DATA_W is 32.
  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    case (size_i)
      SZ_BYTE: begin keep = DATA_W'(8'hFF);        sign_bit = shifted[7];        end
      SZ_HALF: begin keep = DATA_W'(16'hFFFF);     sign_bit = shifted[15];       end
      SZ_WORD: begin keep = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31];      end
      default: begin keep = '1;                    sign_bit = shifted[DATA_W-1]; end
    endcase
    rdata_ext_o = (shifted & keep) | ((signed_i && sign_bit) ? ~keep : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline memory stage. Runs one LDR/STR at a time against
// an external data memory with variable latency.
//   in_*        upstream op channel (accept = in_valid && in_ready)
//   cur_epoch   global branch epoch; ops from another epoch are dropped
//   flush       suppresses the writeback of the op in flight
//   mem_req_*   request channel (accept = mem_req_valid && mem_req_ready)
//   mem_rsp_*   load response (valid only, no back-pressure)
//   wb_*        one-cycle register writeback per completed load
//   err_*       one-cycle error pulses
//   dbg_state   current FSM state
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; while valid is high and ready low, the sender holds every field
// stable. in_ready is high only in IDLE; the memory channel never drops
// mem_req_valid until the request is accepted.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int EPOCH_W = 1,
  parameter int TIMEOUT = 255,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(NB),
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [1:0]         in_size,
  input  logic               in_signed,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [3:0]         in_rd,
  input  logic [EPOCH_W-1:0] in_epoch,
  input  logic [EPOCH_W-1:0] cur_epoch,
  input  logic               flush,
  output logic               stall,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_we,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic [DATA_W-1:0]  mem_req_wdata,
  output logic [NB-1:0]      mem_req_be,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_rdata,
  output logic               wb_valid,
  output logic [3:0]         wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               err_misalign,
  output logic               err_timeout,
  output state_e             dbg_state
);

  state_e             state_q;
  logic               we_q;
  size_e              size_q;
  logic               signed_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [3:0]         rd_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               flush_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wb_valid_q;
  logic [3:0]         wb_rd_q;
  logic [DATA_W-1:0]  wb_data_q;
  logic               err_mis_q;
  logic               err_to_q;

  logic               is_mem_op;
  logic               misaligned;
  logic               flush_evt;
  logic               timeout_hit;
  logic               in_req;
  logic [NB-1:0]      be;
  logic [DATA_W-1:0]  wdata_rep;
  logic [DATA_W-1:0]  rdata_ext;

  assign is_mem_op = (in_op == OP_LDR) || (in_op == OP_STR);

  always_comb begin
    misaligned = 1'b0;
    case (size_e'(in_size))
      SZ_HALF:  misaligned = in_addr[0];
      SZ_WORD:  misaligned = |in_addr[1:0];
      SZ_DWORD: misaligned = (|in_addr[2:0]) || (DATA_W == 32);
      default:  misaligned = 1'b0;
    endcase
  end

  // A branch that moved the epoch away from the op's own epoch kills its
  // writeback exactly like an explicit flush.
  assign flush_evt   = flush || (cur_epoch != epoch_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i      (size_q),
    .signed_i    (signed_q),
    .lane_i      (addr_q[LANE_W-1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rsp_rdata),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .rdata_ext_o (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      epoch_q    <= '0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            we_q     <= (in_op == OP_STR);
            size_q   <= size_e'(in_size);
            signed_q <= in_signed;
            addr_q   <= in_addr;
            wdata_q  <= in_wdata;
            rd_q     <= in_rd;
            epoch_q  <= in_epoch;
            flush_q  <= 1'b0;
            // Squash takes precedence over the alignment check: an op from
            // a dead epoch never raises an error.
            if (is_mem_op && (in_epoch == cur_epoch)) begin
              if (misaligned) err_mis_q <= 1'b1;
              else            state_q   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (flush_evt) flush_q <= 1'b1;
          if (mem_req_ready) begin
            if (we_q) begin
              state_q <= ST_IDLE;
              flush_q <= 1'b0;
            end else begin
              state_q <= ST_RSP;
              cnt_q   <= '0;
            end
          end
        end
        ST_RSP: begin
          if (flush_evt) flush_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          // The timeout wins over a coincident response; that response is
          // then treated as unrelated and DRAIN waits for the next one.
          if (timeout_hit) begin
            err_to_q <= 1'b1;
            state_q  <= ST_DRAIN;
          end else if (mem_rsp_valid) begin
            wb_valid_q <= !(flush_q || flush_evt);
            wb_rd_q    <= rd_q;
            wb_data_q  <= rdata_ext;
            state_q    <= ST_IDLE;
            flush_q    <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (mem_rsp_valid) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_req        = (state_q == ST_REQ);
  assign in_ready      = (state_q == ST_IDLE);
  assign stall         = in_valid && !in_ready;
  assign mem_req_valid = in_req;
  assign mem_req_we    = in_req && we_q;
  assign mem_req_addr  = in_req ? {addr_q[ADDR_W-1:LANE_W], LANE_W'(0)} : '0;
  assign mem_req_wdata = in_req ? wdata_rep : '0;
  assign mem_req_be    = in_req ? be : '0;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign err_misalign  = err_mis_q;
  assign err_timeout   = err_to_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_pkg::*;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cur_epoch = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  // 32-bit instance, default timeout
  logic        a_in_valid, a_in_ready, a_in_signed, a_stall;
  logic [1:0]  a_in_op, a_in_size;
  logic [31:0] a_in_addr, a_in_wdata;
  logic [3:0]  a_in_rd;
  logic        a_in_epoch;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_req_we;
  logic [31:0] a_mem_req_addr, a_mem_req_wdata;
  logic [3:0]  a_mem_req_be;
  logic        a_mem_rsp_valid;
  logic [31:0] a_mem_rsp_rdata;
  logic        a_wb_valid, a_err_misalign, a_err_timeout;
  logic [3:0]  a_wb_rd;
  logic [31:0] a_wb_data;
  state_e      a_dbg_state;

  // 64-bit instance, short timeout
  logic        b_in_valid, b_in_ready, b_in_signed, b_stall;
  logic [1:0]  b_in_op, b_in_size;
  logic [31:0] b_in_addr;
  logic [63:0] b_in_wdata;
  logic [3:0]  b_in_rd;
  logic        b_in_epoch;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_req_we;
  logic [31:0] b_mem_req_addr;
  logic [63:0] b_mem_req_wdata;
  logic [7:0]  b_mem_req_be;
  logic        b_mem_rsp_valid;
  logic [63:0] b_mem_rsp_rdata;
  logic        b_wb_valid, b_err_misalign, b_err_timeout;
  logic [3:0]  b_wb_rd;
  logic [63:0] b_wb_data;
  state_e      b_dbg_state;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .EPOCH_W(1), .TIMEOUT(255)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_size(a_in_size),
    .in_signed(a_in_signed), .in_addr(a_in_addr), .in_wdata(a_in_wdata), .in_rd(a_in_rd),
    .in_epoch(a_in_epoch), .cur_epoch(cur_epoch), .flush(flush), .stall(a_stall),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready), .mem_req_we(a_mem_req_we),
    .mem_req_addr(a_mem_req_addr), .mem_req_wdata(a_mem_req_wdata), .mem_req_be(a_mem_req_be),
    .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_rdata(a_mem_rsp_rdata),
    .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
    .err_misalign(a_err_misalign), .err_timeout(a_err_timeout), .dbg_state(a_dbg_state)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .EPOCH_W(1), .TIMEOUT(4)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_size(b_in_size),
    .in_signed(b_in_signed), .in_addr(b_in_addr), .in_wdata(b_in_wdata), .in_rd(b_in_rd),
    .in_epoch(b_in_epoch), .cur_epoch(cur_epoch), .flush(flush), .stall(b_stall),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_req_we(b_mem_req_we),
    .mem_req_addr(b_mem_req_addr), .mem_req_wdata(b_mem_req_wdata), .mem_req_be(b_mem_req_be),
    .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_rdata(b_mem_rsp_rdata),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .err_misalign(b_err_misalign), .err_timeout(b_err_timeout), .dbg_state(b_dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = 0; a_in_op = OP_NONE; a_in_size = SZ_BYTE; a_in_signed = 0;
    a_in_addr = '0; a_in_wdata = '0; a_in_rd = '0; a_in_epoch = 0;
    a_mem_req_ready = 0; a_mem_rsp_valid = 0; a_mem_rsp_rdata = '0;
    b_in_valid = 0; b_in_op = OP_NONE; b_in_size = SZ_BYTE; b_in_signed = 0;
    b_in_addr = '0; b_in_wdata = '0; b_in_rd = '0; b_in_epoch = 0;
    b_mem_req_ready = 0; b_mem_rsp_valid = 0; b_mem_rsp_rdata = '0;
    cur_epoch = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic drive_a(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] rd);
    a_in_valid = 1; a_in_op = op; a_in_size = size; a_in_signed = sgn;
    a_in_addr = addr; a_in_wdata = wdata; a_in_rd = rd;
  endtask

  task automatic drive_b(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [3:0] rd);
    b_in_valid = 1; b_in_op = op; b_in_size = size; b_in_signed = sgn;
    b_in_addr = addr; b_in_wdata = '0; b_in_rd = rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    checks++;
    if ({a_in_ready, a_mem_req_valid, a_mem_req_be, a_wb_valid, a_err_misalign, a_err_timeout, a_stall} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a32 rdy=%b reqv=%b be=%h wbv=%b mis=%b to=%b stall=%b want rdy=1 others 0",
               a_in_ready, a_mem_req_valid, a_mem_req_be, a_wb_valid, a_err_misalign, a_err_timeout, a_stall);
    end
    checks++;
    if ({b_in_ready, b_mem_req_valid, b_mem_req_be, b_wb_valid, b_wb_data, b_err_timeout} !== {1'b1, 1'b0, 8'h00, 1'b0, 64'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_b64 rdy=%b reqv=%b be=%h wbv=%b wbd=%h to=%b want rdy=1 others 0",
               b_in_ready, b_mem_req_valid, b_mem_req_be, b_wb_valid, b_wb_data, b_err_timeout);
    end
    checks++;
    if (a_dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d want=%0d", a_dbg_state, ST_IDLE);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_store_word();
    do_reset();
    drive_a(OP_STR, SZ_WORD, 1'b0, 32'h104, 32'hDEAD_BEEF, 4'd1);
    #1;
    checks++;
    if ({a_in_ready, a_stall} !== 2'b10) begin
      failures++;
      $display("FAIL store_accept rdy/stall got=%b want=10", {a_in_ready, a_stall});
    end
    tick();
    a_in_op = OP_NONE;  // upstream keeps presenting; it must see a stall
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({a_mem_req_valid, a_mem_req_we, a_mem_req_addr, a_mem_req_wdata, a_mem_req_be} !==
          {1'b1, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF}) begin
        failures++;
        $display("FAIL store_req_c%0d v=%b we=%b addr=%h wd=%h be=%h want v=1 we=1 addr=104 wd=deadbeef be=f",
                 i, a_mem_req_valid, a_mem_req_we, a_mem_req_addr, a_mem_req_wdata, a_mem_req_be);
      end
      checks++;
      if ({a_stall, a_in_ready, a_wb_valid} !== 3'b100) begin
        failures++;
        $display("FAIL store_stall_c%0d stall/rdy/wbv got=%b want=100", i, {a_stall, a_in_ready, a_wb_valid});
      end
      if (i == 3) a_mem_req_ready = 1;
      tick();
    end
    a_mem_req_ready = 0;
    a_in_valid = 0;
    #1;
    checks++;
    if ({a_mem_req_valid, a_in_ready, a_wb_valid} !== 3'b010) begin
      failures++;
      $display("FAIL store_done reqv/rdy/wbv got=%b want=010", {a_mem_req_valid, a_in_ready, a_wb_valid});
    end
  endtask

  task automatic test_load_signed_byte();
    do_reset();
    a_mem_req_ready = 1;
    drive_a(OP_LDR, SZ_BYTE, 1'b1, 32'h103, 32'h0, 4'd5);
    tick();
    a_in_valid = 0;
    #1;
    checks++;
    if ({a_mem_req_valid, a_mem_req_we, a_mem_req_addr, a_mem_req_be} !== {1'b1, 1'b0, 32'h100, 4'h8}) begin
      failures++;
      $display("FAIL ldb_req v=%b we=%b addr=%h be=%h want v=1 we=0 addr=100 be=8",
               a_mem_req_valid, a_mem_req_we, a_mem_req_addr, a_mem_req_be);
    end
    tick();
    a_mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({a_mem_req_valid, a_wb_valid, a_in_ready} !== 3'b000) begin
        failures++;
        $display("FAIL ldb_wait_c%0d reqv/wbv/rdy got=%b want=000", i, {a_mem_req_valid, a_wb_valid, a_in_ready});
      end
      tick();
    end
    a_mem_rsp_valid = 1;
    a_mem_rsp_rdata = 32'h8000_0000;
    tick();
    a_mem_rsp_valid = 0;
    checks++;
    if ({a_wb_valid, a_wb_rd, a_wb_data} !== {1'b1, 4'd5, 32'hFFFF_FF80}) begin
      failures++;
      $display("FAIL ldb_wb v=%b rd=%0d data=%h want v=1 rd=5 data=ffffff80", a_wb_valid, a_wb_rd, a_wb_data);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ldb_ready_at_wb got=%b want=1", a_in_ready);
    end
    tick();
    checks++;
    if (a_wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL ldb_wb_pulse got=%b want=0", a_wb_valid);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    drive_a(OP_LDR, SZ_HALF, 1'b0, 32'h101, 32'h0, 4'd2);
    tick();
    // back-to-back: dword on a 32-bit bus, then a misaligned word
    drive_a(OP_LDR, SZ_DWORD, 1'b0, 32'h100, 32'h0, 4'd2);
    checks++;
    if ({a_err_misalign, a_mem_req_valid, a_in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL mis_half err/reqv/rdy got=%b want=101", {a_err_misalign, a_mem_req_valid, a_in_ready});
    end
    tick();
    drive_a(OP_STR, SZ_WORD, 1'b0, 32'h102, 32'h55, 4'd0);
    checks++;
    if ({a_err_misalign, a_mem_req_valid, a_in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL mis_dword32 err/reqv/rdy got=%b want=101", {a_err_misalign, a_mem_req_valid, a_in_ready});
    end
    tick();
    a_in_valid = 0;
    checks++;
    if ({a_err_misalign, a_mem_req_valid} !== 2'b10) begin
      failures++;
      $display("FAIL mis_word err/reqv got=%b want=10", {a_err_misalign, a_mem_req_valid});
    end
    tick();
    checks++;
    if ({a_err_misalign, a_mem_req_valid, a_in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL mis_clear err/reqv/rdy got=%b want=001", {a_err_misalign, a_mem_req_valid, a_in_ready});
    end
  endtask

  task automatic test_epoch();
    do_reset();
    cur_epoch = 1;
    a_in_epoch = 0;
    drive_a(OP_LDR, SZ_WORD, 1'b0, 32'h200, 32'h0, 4'd6);
    tick();
    tick();
    a_in_valid = 0;
    checks++;
    if ({a_in_ready, a_mem_req_valid, a_err_misalign} !== 3'b100) begin
      failures++;
      $display("FAIL squash rdy/reqv/mis got=%b want=100", {a_in_ready, a_mem_req_valid, a_err_misalign});
    end
    // same-epoch load, epoch flips and returns while waiting for the data
    a_in_epoch = 1;
    a_mem_req_ready = 1;
    drive_a(OP_LDR, SZ_WORD, 1'b0, 32'h200, 32'h0, 4'd7);
    tick();
    a_in_valid = 0;
    checks++;
    if (a_mem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL epoch_req reqv got=%b want=1", a_mem_req_valid);
    end
    tick();
    a_mem_req_ready = 0;
    cur_epoch = 0;
    tick();
    cur_epoch = 1;
    tick();
    a_mem_rsp_valid = 1;
    a_mem_rsp_rdata = 32'h1122_3344;
    tick();
    a_mem_rsp_valid = 0;
    checks++;
    if ({a_wb_valid, a_in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL epoch_flush wbv/rdy got=%b want=01", {a_wb_valid, a_in_ready});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    b_mem_req_ready = 1;
    drive_b(OP_LDR, SZ_WORD, 1'b0, 32'h10, 4'd3);
    tick();
    b_in_valid = 0;
    tick();  // request handshake on this edge
    b_mem_req_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (b_err_timeout !== (i == 4)) begin
        failures++;
        $display("FAIL timeout_c%0d err_timeout got=%b want=%b", i, b_err_timeout, (i == 4));
      end
    end
    checks++;
    if ({b_wb_valid, b_in_ready} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_drain wbv/rdy got=%b want=00", {b_wb_valid, b_in_ready});
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if ({b_err_timeout, b_in_ready} !== 2'b00) begin
      failures++;
      $display("FAIL drain_wait to/rdy got=%b want=00", {b_err_timeout, b_in_ready});
    end
    b_mem_rsp_valid = 1;
    b_mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    b_mem_rsp_valid = 0;
    checks++;
    if ({b_wb_valid, b_in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL drain_discard wbv/rdy got=%b want=01", {b_wb_valid, b_in_ready});
    end
    // next load runs normally
    b_mem_req_ready = 1;
    drive_b(OP_LDR, SZ_WORD, 1'b0, 32'h14, 4'd9);
    tick();
    b_in_valid = 0;
    checks++;
    if ({b_mem_req_valid, b_mem_req_addr, b_mem_req_be} !== {1'b1, 32'h10, 8'hF0}) begin
      failures++;
      $display("FAIL after_to_req v=%b addr=%h be=%h want v=1 addr=10 be=f0", b_mem_req_valid, b_mem_req_addr, b_mem_req_be);
    end
    tick();
    b_mem_req_ready = 0;
    b_mem_rsp_valid = 1;
    b_mem_rsp_rdata = 64'hCAFE_BABE_0000_0000;
    tick();
    b_mem_rsp_valid = 0;
    checks++;
    if ({b_wb_valid, b_wb_rd, b_wb_data} !== {1'b1, 4'd9, 64'h0000_0000_CAFE_BABE}) begin
      failures++;
      $display("FAIL after_to_wb v=%b rd=%0d data=%h want v=1 rd=9 data=cafebabe", b_wb_valid, b_wb_rd, b_wb_data);
    end
  endtask

  task automatic test_half64_and_reset();
    do_reset();
    b_mem_req_ready = 1;
    drive_b(OP_LDR, SZ_HALF, 1'b0, 32'h6, 4'd2);
    tick();
    b_in_valid = 0;
    checks++;
    if ({b_mem_req_valid, b_mem_req_addr, b_mem_req_be} !== {1'b1, 32'h0, 8'hC0}) begin
      failures++;
      $display("FAIL h64_req v=%b addr=%h be=%h want v=1 addr=0 be=c0", b_mem_req_valid, b_mem_req_addr, b_mem_req_be);
    end
    tick();
    b_mem_rsp_valid = 1;
    b_mem_rsp_rdata = 64'h1234_0000_0000_0000;
    tick();
    b_mem_rsp_valid = 0;
    checks++;
    if ({b_wb_valid, b_wb_rd, b_wb_data} !== {1'b1, 4'd2, 64'h1234}) begin
      failures++;
      $display("FAIL h64_wb v=%b rd=%0d data=%h want v=1 rd=2 data=1234", b_wb_valid, b_wb_rd, b_wb_data);
    end
    // park a load in RSP and hit it with reset
    drive_b(OP_LDR, SZ_WORD, 1'b0, 32'h8, 4'd4);
    tick();
    b_in_valid = 0;
    tick();
    b_mem_req_ready = 0;
    checks++;
    if (b_dbg_state !== ST_RSP) begin
      failures++;
      $display("FAIL rst_pre_state got=%0d want=%0d", b_dbg_state, ST_RSP);
    end
    rst = 1;
    #1;
    checks++;
    if ({b_in_ready, b_mem_req_valid, b_wb_valid, b_wb_data, b_err_timeout, b_mem_req_be} !==
        {1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL rst_in_rsp rdy=%b reqv=%b wbv=%b wbd=%h to=%b be=%h want rdy=1 others 0",
               b_in_ready, b_mem_req_valid, b_wb_valid, b_wb_data, b_err_timeout, b_mem_req_be);
    end
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_signed_byte();
    test_misalign();
    test_epoch();
    test_timeout();
    test_half64_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
